// File: rtl/uart_rx_fsm_if.sv
// Purpose: bundles the UART receiver's tick/line inputs and its word/status outputs.
// Latency: none, wiring only.
// Backpressure: none; the receiver pulses data_valid/frame_err and never stalls.
// Ports: tick (oversample strobe), rx (serial line), data_out, data_valid,
//        frame_err, busy.
interface uart_rx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  // master drives the line and strobe and observes results.
  modport master (output tick, rx, input data_out, data_valid, frame_err, busy);
  // slave is the receiver itself.
  modport slave  (input tick, rx, output data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_fsm.sv
// Purpose: oversampled UART receiver (start, DATA_BITS data LSB first, one stop bit).
// Latency: 2 clk synchronizer; result pulses 1 clk after the stop-bit sample tick.
// Backpressure: none; a new word overwrites data_out, the sender must pace frames.
// Ports: clk, reset (async, active-low), bus.tick (OVERSAMPLE x baud strobe),
//        bus.rx (async line, idle high), bus.data_out / data_valid / frame_err, bus.busy.
module uart_rx_fsm #(
  parameter int DATA_BITS  = 8,   // 5..8
  parameter int OVERSAMPLE = 16   // even, 8..16
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fsm_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Start bit is confirmed at its middle; later bits are then sampled a full
  // bit period apart, which keeps every sample near mid-bit.
  localparam logic [3:0] TC_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BC_LAST = 3'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Falling edge is acted on immediately, independent of tick.
        tcnt_d = '0;
        if (!rx_s_q) state_d = START;
      end

      START: begin
        if (bus.tick) begin
          if (tcnt_q == TC_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            // Line back high at mid-start means a glitch: drop silently.
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (bus.tick) begin
          if (tcnt_q == TC_LAST) begin
            tcnt_d  = '0;
            // LSB arrives first, so shift right and enter at the MSB.
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bcnt_q == BC_LAST) state_d = STOP;
            else                   bcnt_d  = bcnt_q + 3'd1;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      STOP: begin
        if (bus.tick) begin
          if (tcnt_q == TC_LAST) begin
            tcnt_d  = '0;
            state_d = IDLE;
            if (rx_s_q) begin
              data_out_d   = shreg_q;
              data_valid_d = 1'b1;
            end else begin
              frame_err_d  = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
